turn_signal_ctrl: RTL and testbench

Sequencing controller for the six-lamp rear tail-light cluster (lc lb la | ra rb rc). It latches left and right turn requests and a hazard request, and arbitrates between them. It runs the three-step sweep pattern at a programmable step rate. An optional brake overlay is included. It replaces free-running per-clock stepping with a prescaled, queued, priority-arbitrated scheduler.

---
 rtl/tail_light_pkg.sv | 47 ++++
 rtl/tick_prescaler.sv | 41 ++++
 rtl/turn_signal_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_turn_signal_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/tail_light_pkg.sv
// ============================================================================
//  Module      : tail_light_pkg
//  Description : Shared types, lamp patterns and helpers for the six-lamp
//                turn-signal sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package tail_light_pkg;

    // Controller states; 4 bits covers all eleven phases.
    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        L1    = 4'd1,
        L2    = 4'd2,
        L3    = 4'd3,
        LOFF  = 4'd4,
        R1    = 4'd5,
        R2    = 4'd6,
        R3    = 4'd7,
        ROFF  = 4'd8,
        H_ON  = 4'd9,
        H_OFF = 4'd10
    } state_t;

    // Lamp patterns per side, bit order {outer, middle, inner}.
    localparam logic [2:0] PAT_OFF = 3'b000;
    localparam logic [2:0] PAT_1   = 3'b001;
    localparam logic [2:0] PAT_2   = 3'b011;
    localparam logic [2:0] PAT_3   = 3'b111;

    // Counter width able to hold values 0..n-1, never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Fixed-priority choice of the next activity: hazard, then left, then right.
    function automatic state_t pick_next(input logic hz, input logic lt, input logic rt);
        if (hz)      return H_ON;
        else if (lt) return L1;
        else if (rt) return R1;
        else         return IDLE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
//  Module      : tick_prescaler
//  Description : Phase-length counter. Counts 0..TICK_DIV-1 and flags the
//                last cycle of a phase; a clear restarts the count at 0.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import tail_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned         c_W    = cnt_width(TICK_DIV);
    localparam logic [c_W-1:0]      c_LAST = c_W'(TICK_DIV - 1);
    localparam logic [c_W-1:0]      c_ONE  = c_W'(1);

    logic [c_W-1:0] r_count;

    assign tick = (r_count == c_LAST);

    // Phase counter: restarts on clear or after the last cycle of a phase.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (clear || tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/turn_signal_ctrl.sv
// ============================================================================
//  Module      : turn_signal_ctrl
//  Description : Six-lamp tail-light sequencer with latched left/right
//                requests, hazard priority and a prescaled sweep pattern.
//                Optional brake overlay enabled by TURN_SIGNAL_BRAKE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module turn_signal_ctrl
    import tail_light_pkg::*;
#(
    parameter int unsigned TICK_DIV = 4,
    parameter int unsigned SWEEPS   = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic left_req,
    input  logic right_req,
    input  logic hazard_req,
    input  logic brake,
    output logic la,
    output logic lb,
    output logic lc,
    output logic ra,
    output logic rb,
    output logic rc,
    output logic busy
);

    localparam int unsigned          c_SW_W   = cnt_width(SWEEPS + 1);
    localparam logic [c_SW_W-1:0]    c_SWEEPS = c_SW_W'(SWEEPS);
    localparam logic [c_SW_W-1:0]    c_ONE    = c_SW_W'(1);

    state_t              r_state;
    state_t              w_next;
    logic [c_SW_W-1:0]   r_sweeps;
    logic                r_pend_l;
    logic                r_pend_r;
    logic                w_tick;
    logic                w_clear;
    logic                w_in_left;
    logic                w_in_right;
    logic                w_want_l;
    logic                w_want_r;
    logic                w_continue;
    logic                w_start;
    logic [2:0]          w_lpat;
    logic [2:0]          w_rpat;
    logic                w_brake_on;

    assign w_in_left  = r_state inside {L1, L2, L3, LOFF};
    assign w_in_right = r_state inside {R1, R2, R3, ROFF};
    assign w_want_l   = left_req  | r_pend_l;
    assign w_want_r   = right_req | r_pend_r;

    // Another sweep in the same direction follows this OFF phase.
    assign w_continue = (r_state == LOFF || r_state == ROFF) && w_tick &&
                        !hazard_req && (r_sweeps > c_ONE);

    // A fresh sweep episode begins (not a repeat of the running one).
    assign w_start = ((w_next == L1) || (w_next == R1)) &&
                     (w_next != r_state) && !w_continue;

    // The phase counter restarts on every state change and idles at zero.
    assign w_clear = (w_next != r_state) || (r_state == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (w_clear),
        .tick  (w_tick)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: phases advance on tick; OFF phases are the only exit points.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:  w_next = pick_next(hazard_req, w_want_l, w_want_r);
            L1:    if (w_tick) w_next = L2;
            L2:    if (w_tick) w_next = L3;
            L3:    if (w_tick) w_next = LOFF;
            LOFF: begin
                if (w_tick) begin
                    if (hazard_req)               w_next = H_ON;
                    else if (r_sweeps > c_ONE)    w_next = L1;
                    else                          w_next = pick_next(1'b0, w_want_l, w_want_r);
                end
            end
            R1:    if (w_tick) w_next = R2;
            R2:    if (w_tick) w_next = R3;
            R3:    if (w_tick) w_next = ROFF;
            ROFF: begin
                if (w_tick) begin
                    if (hazard_req)               w_next = H_ON;
                    else if (r_sweeps > c_ONE)    w_next = R1;
                    else                          w_next = pick_next(1'b0, w_want_l, w_want_r);
                end
            end
            H_ON:  if (w_tick) w_next = H_OFF;
            H_OFF: begin
                if (w_tick) begin
                    w_next = pick_next(hazard_req, w_want_l, w_want_r);
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Sweep counter and pending-request latches.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sweeps <= '0;
            r_pend_l <= 1'b0;
            r_pend_r <= 1'b0;
        end else begin
            if (w_start) begin
                r_sweeps <= c_SWEEPS;
            end else if ((w_in_left && left_req) || (w_in_right && right_req)) begin
                r_sweeps <= c_SWEEPS;
            end else if (w_continue) begin
                r_sweeps <= r_sweeps - c_ONE;
            end

            // A same-direction request extends the running sweep instead of queuing.
            if (w_next == L1 && !w_in_left) begin
                r_pend_l <= 1'b0;
            end else if (left_req && !w_in_left) begin
                r_pend_l <= 1'b1;
            end

            if (w_next == R1 && !w_in_right) begin
                r_pend_r <= 1'b0;
            end else if (right_req && !w_in_right) begin
                r_pend_r <= 1'b1;
            end
        end
    end

`ifdef TURN_SIGNAL_BRAKE_EN
    logic r_brake;

    // Brake is registered so lamps never depend combinationally on inputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_brake <= 1'b0;
        end else begin
            r_brake <= brake;
        end
    end

    assign w_brake_on = r_brake;
`else
    logic w_unused_brake;
    assign w_unused_brake = brake;
    assign w_brake_on     = 1'b0;
`endif

    // Lamp decode from the registered state, with brake filling idle sides.
    always_comb begin
        w_lpat = PAT_OFF;
        w_rpat = PAT_OFF;
        case (r_state)
            L1:      w_lpat = PAT_1;
            L2:      w_lpat = PAT_2;
            L3:      w_lpat = PAT_3;
            R1:      w_rpat = PAT_1;
            R2:      w_rpat = PAT_2;
            R3:      w_rpat = PAT_3;
            H_ON: begin
                w_lpat = PAT_3;
                w_rpat = PAT_3;
            end
            default: ;
        endcase
        if (w_brake_on) begin
            if (r_state == IDLE) begin
                w_lpat = PAT_3;
                w_rpat = PAT_3;
            end else if (w_in_left) begin
                w_rpat = PAT_3;
            end else if (w_in_right) begin
                w_lpat = PAT_3;
            end
        end
    end

    assign la   = w_lpat[0];
    assign lb   = w_lpat[1];
    assign lc   = w_lpat[2];
    assign ra   = w_rpat[0];
    assign rb   = w_rpat[1];
    assign rc   = w_rpat[2];
    assign busy = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_turn_signal_ctrl.sv
// ============================================================================
//  Module      : tb_turn_signal_ctrl
//  Description : Directed self-checking bench for turn_signal_ctrl with
//                TICK_DIV=2, SWEEPS=1. Honours TURN_SIGNAL_BRAKE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_turn_signal_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic left_req = 1'b0;
    logic right_req = 1'b0;
    logic hazard_req = 1'b0;
    logic brake = 1'b0;
    logic la, lb, lc, ra, rb, rc, busy;
    logic [6:0] w_obs;

    int n_total = 0;
    int n_bad   = 0;

    // Expected vector layout {busy, lc, lb, la, ra, rb, rc}.
    localparam logic [6:0] c_IDLE = 7'b0_000_000;
    localparam logic [6:0] c_L1   = 7'b1_001_000;
    localparam logic [6:0] c_L2   = 7'b1_011_000;
    localparam logic [6:0] c_L3   = 7'b1_111_000;
    localparam logic [6:0] c_R1   = 7'b1_000_100;
    localparam logic [6:0] c_R2   = 7'b1_000_110;
    localparam logic [6:0] c_R3   = 7'b1_000_111;
    localparam logic [6:0] c_OFF  = 7'b1_000_000;
    localparam logic [6:0] c_HON  = 7'b1_111_111;
`ifdef TURN_SIGNAL_BRAKE_EN
    localparam logic [6:0] c_BRK_L = 7'b0_111_000;
    localparam logic [6:0] c_BRK_R = 7'b0_000_111;
`else
    localparam logic [6:0] c_BRK_L = 7'b0_000_000;
    localparam logic [6:0] c_BRK_R = 7'b0_000_000;
`endif

    logic [6:0] exp_q[$];

    turn_signal_ctrl #(
        .TICK_DIV (2),
        .SWEEPS   (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .left_req   (left_req),
        .right_req  (right_req),
        .hazard_req (hazard_req),
        .brake      (brake),
        .la         (la),
        .lb         (lb),
        .lc         (lc),
        .ra         (ra),
        .rb         (rb),
        .rc         (rc),
        .busy       (busy)
    );

    assign w_obs = {busy, lc, lb, la, ra, rb, rc};

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [6:0] got, input logic [6:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push2(input logic [6:0] v);
        exp_q.push_back(v);
        exp_q.push_back(v);
    endtask

    // Check one expected vector per cycle; optionally inject right_req or drop hazard_req.
    task automatic play(input string tag, input int inj_r, input int drop_h);
        for (int i = 0; i < exp_q.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), w_obs, exp_q[i]);
            if (i == inj_r)  right_req  = 1'b1;
            if (i == drop_h) hazard_req = 1'b0;
            step();
            right_req = 1'b0;
        end
        exp_q.delete();
    endtask

    task automatic push_left_sweep(input logic [6:0] brk);
        push2(c_L1 | brk);
        push2(c_L2 | brk);
        push2(c_L3 | brk);
        push2(c_OFF | brk);
    endtask

    task automatic push_right_sweep();
        push2(c_R1);
        push2(c_R2);
        push2(c_R3);
        push2(c_OFF);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        #3;
        chk("rst_hold", w_obs, c_IDLE);
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_idle", w_obs, c_IDLE);

        // 1: single left request
        left_req = 1'b1;
        step();
        left_req = 1'b0;
        push_left_sweep(7'b0);
        exp_q.push_back(c_IDLE);
        play("left", -1, -1);

        // 2: simultaneous left and right, right queued behind left
        left_req  = 1'b1;
        right_req = 1'b1;
        step();
        left_req  = 1'b0;
        right_req = 1'b0;
        push_left_sweep(7'b0);
        push_right_sweep();
        exp_q.push_back(c_IDLE);
        play("both", -1, -1);

        // 3: right request arriving mid left sweep
        left_req = 1'b1;
        step();
        left_req = 1'b0;
        push_left_sweep(7'b0);
        push_right_sweep();
        exp_q.push_back(c_IDLE);
        play("late_r", 3, -1);

        // 4: asynchronous reset during L2
        left_req = 1'b1;
        step();
        left_req = 1'b0;
        chk("ar_l1a", w_obs, c_L1);
        step();
        chk("ar_l1b", w_obs, c_L1);
        step();
        chk("ar_l2", w_obs, c_L2);
        #2;
        reset = 1'b0;
        #1;
        chk("ar_async", w_obs, c_IDLE);
        step();
        chk("ar_held", w_obs, c_IDLE);
        reset = 1'b1;
        step();
        chk("ar_rel1", w_obs, c_IDLE);
        step();
        chk("ar_rel2", w_obs, c_IDLE);

        // 5: hazard held for 10 cycles
        hazard_req = 1'b1;
        step();
        for (int j = 0; j < 3; j++) begin
            push2(c_HON);
            push2(c_OFF);
        end
        exp_q.push_back(c_IDLE);
        play("hazard", -1, 9);

        // Hazard beats a simultaneous left; the left request waits and then runs
        hazard_req = 1'b1;
        left_req   = 1'b1;
        step();
        left_req = 1'b0;
        push2(c_HON);
        push2(c_OFF);
        push_left_sweep(7'b0);
        exp_q.push_back(c_IDLE);
        play("hz_pend", -1, 1);

        // 6: brake overlay during a left sweep
        brake = 1'b1;
        step();
        step();
        chk("brk_idle", w_obs, c_IDLE | c_BRK_L | c_BRK_R);
        left_req = 1'b1;
        step();
        left_req = 1'b0;
        push_left_sweep(c_BRK_R);
        exp_q.push_back(c_IDLE | c_BRK_L | c_BRK_R);
        play("brake", -1, -1);
        brake = 1'b0;
        step();
        step();
        chk("brk_off", w_obs, c_IDLE);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
